bus_xcvr_ba_port: RTL
=====================

Name: bus_xcvr_ba_port

Overview:
- Synchronous FPGA model of the B-to-A half of the ND-120 octal registered inverting bus transceiver, the 74648-style part.
- Takes the active-low B bus, stores it in the BA register on CLKBA rising edges, and drives the inverted data onto the A side.
- A-side data is either real-time or stored, selected by SBA.
- A-side drive enable is gated by DIR and OE_n through a bus-turnaround state machine, which prevents contention with the A-to-B direction.

Parameters:
- WIDTH, 8, width of the A and B buses.
- TURN_CYCLES, 2, number of sysclk cycles the A side stays released after a drive request and before it is driven; 0 means drive immediately.

Ports:
- sysclk  in  1  system clock; all state updates on its rising edge.
- sys_rst_n  in  1  synchronous active-low reset.
- b_n_in  in  WIDTH  B bus, active-low data.
- clkba  in  1  BA register clock level; sampled in sysclk; rising edge is detected.
- sba  in  1  1 = stored BA register to A; 0 = real-time B to A.
- dir  in  1  0 = B-to-A direction; 1 = A-to-B direction.
- oe_n  in  1  active-low output enable.
- a_out  out  WIDTH  A-side data, equal to ~B (true polarity).
- a_oe  out  1  A-side pad drive enable.
- ba_reg  out  WIDTH  current BA register contents (B polarity, active-low).
- ba_valid  out  1  BA register has captured at least once since reset.
- turn_busy  out  1  turnaround in progress (state TURN).

Behaviour:
- Clock and reset: single clock sysclk. Reset is synchronous and active-low (sys_rst_n), sampled on the sysclk rising edge.
- Reset values:
  - ba_reg = all ones (idle B bus).
  - ba_valid = 0.
  - clkba_q = 1, so no spurious capture if clkba is high when reset releases.
  - State = IDLE, so a_oe = 0 and turn_busy = 0.
  - Data register = 0, so a_out = 0.
- Edge detect: clkba_q <= clkba every cycle. cap = clkba & ~clkba_q.
- Capture:
  - If cap in cycle k, ba_reg <= b_n_in sampled in cycle k; the new value is visible in cycle k+1. ba_valid <= 1 in the same cycle.
  - Capture is independent of dir, oe_n and state, as on the real part.
  - clkba held high captures exactly once.
- Data path (registered, 1-cycle latency): data_q <= ~(sba ? ba_reg : b_n_in).
  - When capture and sba=1 occur in the same cycle, data_q takes the old ba_reg. The new value reaches a_out 2 cycles after the cap cycle.
- Output gating: a_out = a_oe ? data_q : 0 (combinational AND with the registered enable).
- Drive request: req = ~oe_n & ~dir.
- FSM (registered state):
  - IDLE: if req and TURN_CYCLES=0, go to DRIVE. If req and TURN_CYCLES>0, go to TURN and load cnt = TURN_CYCLES-1. Otherwise stay in IDLE.
  - TURN: if ~req, go to IDLE. Else if cnt=0, go to DRIVE. Else decrement cnt.
  - DRIVE: if ~req, go to IDLE; the drive is released in the next cycle with no turnaround delay. Otherwise stay in DRIVE.
- Outputs from state: a_oe = (state==DRIVE). turn_busy = (state==TURN).
- Timing: with req rising in cycle k, a_oe = 1 from cycle k+1+TURN_CYCLES.
- req toggling: a req glitch of 1 cycle inside TURN restarts the full turnaround on the next request.
- dir and oe_n changing in the same cycle is evaluated only through req.
- Reset mid-operation overrides everything: a_oe drops on the next edge and ba_reg returns to all ones.
- Counter width: $clog2(TURN_CYCLES+1), minimum 1.

Decomposition:
- Shared package (xcvr_pkg):
  - state enum: IDLE=2'd0, TURN=2'd1, DRIVE=2'd2.
  - DIR_B2A=1'b0, DIR_A2B=1'b1 constants, shared with the A-to-B port block.
- One natural sub-module: xcvr_edge_capture.
  - Contains the clkba synchroniser, the edge detect, ba_reg and ba_valid.
  - Reused by the A-to-B side with clkab.

Test Plan:
- Reset check: hold sys_rst_n=0 for 3 cycles, then release with clkba=1 -> ba_reg=8'hFF, ba_valid=0, a_oe=0, a_out=0. No capture occurs while clkba stays high.
- Real-time path: dir=0, oe_n=0, sba=0, b_n_in=8'h5A.
  - a_oe rises 3 cycles after req (TURN_CYCLES=2).
  - a_out=8'hA5 one cycle after b_n_in changes.
  - Changing b_n_in to 8'h00 gives a_out=8'hFF on the next cycle.
- Stored path: b_n_in=8'h3C, pulse clkba for 1 cycle, then b_n_in=8'hFF, sba=1 -> ba_reg=8'h3C, ba_valid=1, a_out=8'hC3 while driving.
  - Holding clkba high for 5 cycles with b_n_in varying leaves only the first-edge value captured.
- Turnaround abort: assert req, drop dir to 1 in the cycle after -> state returns to IDLE and a_oe never asserts. Re-asserting req needs a full 3 cycles to reach a_oe=1.
- Release: from DRIVE, set oe_n=1 -> a_oe=0 and a_out=0 on the next cycle. With TURN_CYCLES=0, req gives a_oe=1 one cycle later.
- Reset mid-drive: in DRIVE with ba_reg=8'h3C, pulse sys_rst_n=0 for 1 cycle -> a_oe=0, ba_reg=8'hFF, ba_valid=0 next cycle. Turnaround restarts after release.

Source files
------------

// File: rtl/xcvr_pkg.sv
// Types and constants shared by the B-to-A and A-to-B transceiver port blocks.
package xcvr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    DRIVE = 2'd2
  } xcvr_state_e;

  localparam logic DIR_B2A = 1'b0;
  localparam logic DIR_A2B = 1'b1;

  // Turnaround counter width; never narrower than one bit even with no turnaround.
  function automatic int cnt_width(input int turn_cycles);
    int w;
    w = $clog2(turn_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bus_xcvr_ba_port_if.sv
// B-to-A port bundle: B-side data and controls in, A-side drive and status out.
interface bus_xcvr_ba_port_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] b_n_in;
  logic             clkba;
  logic             sba;
  logic             dir;
  logic             oe_n;
  logic [WIDTH-1:0] a_out;
  logic             a_oe;
  logic [WIDTH-1:0] ba_reg;
  logic             ba_valid;
  logic             turn_busy;

  modport slave (
    input  b_n_in, clkba, sba, dir, oe_n,
    output a_out, a_oe, ba_reg, ba_valid, turn_busy
  );

  modport master (
    output b_n_in, clkba, sba, dir, oe_n,
    input  a_out, a_oe, ba_reg, ba_valid, turn_busy
  );
endinterface

// File: rtl/xcvr_edge_capture.sv
// Samples a register-clock level, detects its rising edge and captures data into
// a holding register (1-cycle capture latency); shared by both transceiver directions.
module xcvr_edge_capture #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_lvl,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_reg,
  output logic             o_valid
);

  logic             r_lvl_q;
  logic [WIDTH-1:0] r_reg;
  logic             r_valid;
  logic             w_cap;

  assign w_cap = i_lvl & ~r_lvl_q;

  // r_lvl_q resets high so a level already high at reset release is not an edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lvl_q <= 1'b1;
      r_reg   <= '1;
      r_valid <= 1'b0;
    end else begin
      r_lvl_q <= i_lvl;
      if (w_cap) begin
        r_reg   <= i_dat;
        r_valid <= 1'b1;
      end
    end
  end

  assign o_reg   = r_reg;
  assign o_valid = r_valid;

endmodule

// File: rtl/bus_xcvr_ba_port.sv
// B-to-A half of an inverting registered bus transceiver: real-time or stored data,
// 1-cycle data latency, A-side drive gated by a turnaround FSM to avoid contention.
module bus_xcvr_ba_port
  import xcvr_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2
) (
  input  logic                sysclk,
  input  logic                sys_rst_n,
  bus_xcvr_ba_port_if.slave   bus
);

  localparam int CNT_W = cnt_width(TURN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = (TURN_CYCLES > 0) ? CNT_W'(TURN_CYCLES - 1) : '0;

  xcvr_state_e      r_state;
  xcvr_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_ba_reg;
  logic             w_ba_valid;
  logic             w_req;
  logic             w_a_oe;

  xcvr_edge_capture #(
    .WIDTH (WIDTH)
  ) u_cap (
    .i_clk   (sysclk),
    .i_rst_n (sys_rst_n),
    .i_lvl   (bus.clkba),
    .i_dat   (bus.b_n_in),
    .o_reg   (w_ba_reg),
    .o_valid (w_ba_valid)
  );

  assign w_req = ~bus.oe_n & (bus.dir == DIR_B2A);

  // Stored path reads ba_reg before any same-cycle capture lands.
  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      r_data <= '0;
    end else begin
      r_data <= ~(bus.sba ? w_ba_reg : bus.b_n_in);
    end
  end

  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (TURN_CYCLES == 0) begin
            w_state_nxt = DRIVE;
          end else begin
            w_state_nxt = TURN;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      TURN: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = DRIVE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DRIVE: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_a_oe        = (r_state == DRIVE);
  assign bus.a_oe      = w_a_oe;
  assign bus.turn_busy = (r_state == TURN);
  assign bus.a_out     = w_a_oe ? r_data : '0;
  assign bus.ba_reg    = w_ba_reg;
  assign bus.ba_valid  = w_ba_valid;

endmodule
